// File: rtl/hilo_acc_reg.sv
// HI/LO special-register unit: direct HI/LO writes plus a two-stage multiply-accumulate into {HI,LO}.
// Latency: direct write visible next cycle; accumulate accepted in T commits at end of T+1 (outputs in T+2).
// Backpressure: acc_ready drops for the one cycle a product is in flight; define HILO_BYPASS_EN for same-cycle outputs.
module hilo_acc_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [1:0]       acc_op,
  input  logic [WIDTH-1:0] acc_a,
  input  logic [WIDTH-1:0] acc_b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int AW = 2 * WIDTH;

  // Architectural HI/LO and the stage-1 pipeline register
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             s1_valid_q, s1_valid_d;
  logic [AW-1:0]    prod_q, prod_d;
  logic             sub_q, sub_d;

  logic             accept;
  logic             commit;
  logic [AW-1:0]    a_ext;
  logic [AW-1:0]    b_ext;
  logic [AW-1:0]    product;
  logic [AW-1:0]    acc_cur;
  logic [AW-1:0]    acc_new;

  assign acc_ready = ~s1_valid_q;
  assign busy      = s1_valid_q;
  // A flush both blocks a new request and kills the one in flight
  assign accept    = acc_valid & acc_ready & ~flush;
  assign commit    = s1_valid_q & ~flush;

  // Widen operands to the full accumulator width so one multiply serves signed and unsigned forms
  always_comb begin
    a_ext   = acc_op[1] ? {{WIDTH{1'b0}}, acc_a} : {{WIDTH{acc_a[WIDTH-1]}}, acc_a};
    b_ext   = acc_op[1] ? {{WIDTH{1'b0}}, acc_b} : {{WIDTH{acc_b[WIDTH-1]}}, acc_b};
    product = a_ext * b_ext;
  end

  // Stage 2 folds the registered product into HI:LO as they stand at this edge; carry/borrow drop off
  always_comb begin
    acc_cur = {hi_q, lo_q};
    acc_new = sub_q ? (acc_cur - prod_q) : (acc_cur + prod_q);
  end

  // Next-state: reset first, then direct write per half, then accumulate commit, else hold
  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    s1_valid_d = accept;
    prod_d     = prod_q;
    sub_d      = sub_q;
    if (commit) begin
      hi_d = acc_new[AW-1:WIDTH];
      lo_d = acc_new[WIDTH-1:0];
    end
    if (we_hi) hi_d = hi_i;
    if (we_lo) lo_d = lo_i;
    if (accept) begin
      prod_d = product;
      sub_d  = acc_op[0];
    end
    if (rst) begin
      hi_d       = '0;
      lo_d       = '0;
      s1_valid_d = 1'b0;
      prod_d     = '0;
      sub_d      = 1'b0;
    end
  end

  // State registers; reset is folded into the _d terms so it is synchronous
  always_ff @(posedge clk) begin
    hi_q       <= hi_d;
    lo_q       <= lo_d;
    s1_valid_q <= s1_valid_d;
    prod_q     <= prod_d;
    sub_q      <= sub_d;
  end

`ifdef HILO_BYPASS_EN
  // Expose the next-state values so writers see their result in the same cycle
  always_comb begin
    hi_o = hi_d;
    lo_o = lo_d;
  end
`else
  // Expose the registered values only
  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
  end
`endif

endmodule

// File: tb/tb_hilo_acc_reg.sv
// Bench for hilo_acc_reg: directed literal cases, then randomized traffic against a 64-bit arithmetic model.
// The model keeps HI:LO as one 64-bit number plus a list of products awaiting commit.
// A negedge compare process checks every cycle once the first reset edge has passed.
module tb_hilo_acc_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_hi, we_lo;
  logic [31:0] hi_i, lo_i;
  logic        acc_valid;
  logic        acc_ready;
  logic [1:0]  acc_op;
  logic [31:0] acc_a, acc_b;
  logic        flush;
  logic        busy;
  logic [31:0] hi_o, lo_o;

  hilo_acc_reg #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .we_hi(we_hi), .we_lo(we_lo), .hi_i(hi_i), .lo_i(lo_i),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_op(acc_op), .acc_a(acc_a),
    .acc_b(acc_b), .flush(flush), .busy(busy), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: HI:LO as one number, plus products waiting for their commit edge
  logic [63:0] m_acc = '0;
  logic [63:0] q_prod[$];
  bit          q_sub[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we_hi = 0; we_lo = 0; hi_i = '0; lo_i = '0;
    acc_valid = 0; acc_op = 2'b00; acc_a = '0; acc_b = '0; flush = 0;
  endtask

  // Apply the current inputs for one clock, updating the model to match the edge
  task automatic step();
    logic [63:0] nxt, p;
    logic [31:0] nh, nl;
    bit          take, clr;
    longint      sa, sb;
    nxt = m_acc; take = 0; clr = 0; p = '0;
    if (rst) begin
      nxt = '0;
      clr = 1;
    end else begin
      if (q_prod.size() != 0) begin
        if (!flush) nxt = q_sub[0] ? m_acc - q_prod[0] : m_acc + q_prod[0];
        clr = 1;
      end
      nh = we_hi ? hi_i : nxt[63:32];
      nl = we_lo ? lo_i : nxt[31:0];
      nxt = {nh, nl};
      take = acc_valid && (q_prod.size() == 0) && !flush;
      if (acc_op[1]) begin
        p = {32'b0, acc_a} * {32'b0, acc_b};
      end else begin
        sa = longint'(signed'(acc_a));
        sb = longint'(signed'(acc_b));
        p  = 64'(sa * sb);
      end
    end
    @(posedge clk);
    m_acc = nxt;
    if (clr) begin q_prod.delete(); q_sub.delete(); end
    if (take) begin q_prod.push_back(p); q_sub.push_back(acc_op[0]); end
    #1;
    chk_en = 1'b1;
  endtask

  // Literal expectation checked against both the DUT and the model
  task automatic lit(input string name, input logic [31:0] hi, input logic [31:0] lo);
    chk({name, "_hi"}, {32'b0, hi_o}, {32'b0, hi});
    chk({name, "_lo"}, {32'b0, lo_o}, {32'b0, lo});
    chk({name, "_model"}, m_acc, {hi, lo});
  endtask

  task automatic preload(input logic [31:0] hi, input logic [31:0] lo);
    idle(); we_hi = 1; we_lo = 1; hi_i = hi; lo_i = lo; step(); idle();
  endtask

  // Per-cycle comparison of DUT outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc_hi", {32'b0, hi_o}, {32'b0, m_acc[63:32]});
        chk("cyc_lo", {32'b0, lo_o}, {32'b0, m_acc[31:0]});
        chk("cyc_ready", {63'b0, acc_ready}, {63'b0, q_prod.size() == 0});
        chk("cyc_busy", {63'b0, busy}, {63'b0, q_prod.size() != 0});
      end
    end
  end

  initial begin
    int acc_cnt;
    int acc_pat;
    idle();
    rst = 1;
    step(); step();
    rst = 0;
    lit("reset", 32'h0, 32'h0);
    chk("reset_ready", {63'b0, acc_ready}, 64'd1);
    chk("reset_busy", {63'b0, busy}, 64'd0);

    // Direct writes, each half alone
    we_hi = 1; hi_i = 32'h12345678; step(); idle();
    lit("wr_hi", 32'h12345678, 32'h0);
    we_lo = 1; lo_i = 32'hCAFEBABE; step(); idle();
    lit("wr_lo", 32'h12345678, 32'hCAFEBABE);

    // Signed add: -1 * 2
    preload(32'h0, 32'h0);
    chk("pre_ready", {63'b0, acc_ready}, 64'd1);
    acc_valid = 1; acc_op = 2'b00; acc_a = 32'hFFFFFFFF; acc_b = 32'd2; step(); idle();
    chk("t1_ready", {63'b0, acc_ready}, 64'd0);
    step();
    chk("t2_ready", {63'b0, acc_ready}, 64'd1);
    lit("smadd", 32'hFFFFFFFF, 32'hFFFFFFFE);

    // Unsigned subtract wraps, then unsigned add of the largest product
    preload(32'h0, 32'h0);
    acc_valid = 1; acc_op = 2'b11; acc_a = 32'd1; acc_b = 32'd1; step(); idle(); step();
    lit("umsub", 32'hFFFFFFFF, 32'hFFFFFFFF);
    acc_valid = 1; acc_op = 2'b10; acc_a = 32'hFFFFFFFF; acc_b = 32'hFFFFFFFF; step(); idle(); step();
    lit("umadd", 32'hFFFFFFFE, 32'h00000000);

    // Back-to-back: valid held for 4 cycles, accepts only on cycles 0 and 2
    preload(32'h0, 32'h0);
    acc_cnt = 0; acc_pat = 0;
    acc_valid = 1; acc_op = 2'b00; acc_a = 32'd1; acc_b = 32'd1;
    for (int i = 0; i < 4; i++) begin
      if (acc_ready) begin acc_cnt++; acc_pat |= (1 << i); end
      step();
    end
    idle();
    chk("b2b_count", 64'(acc_cnt), 64'd2);
    chk("b2b_pattern", 64'(acc_pat), 64'd5);
    lit("b2b_sum", 32'h0, 32'h2);

    // Collision: direct LO write on the commit edge wins LO, HI takes the sum
    preload(32'h1, 32'hFFFFFFFF);
    acc_valid = 1; acc_op = 2'b10; acc_a = 32'd1; acc_b = 32'd1; step(); idle();
    we_lo = 1; lo_i = 32'hAAAA5555; step(); idle();
    lit("collide", 32'h2, 32'hAAAA5555);

    // Flush in T+1 cancels the commit
    preload(32'h5, 32'h6);
    acc_valid = 1; acc_a = 32'd7; acc_b = 32'd7; step(); idle();
    flush = 1; step(); idle();
    lit("flush", 32'h5, 32'h6);
    chk("flush_ready", {63'b0, acc_ready}, 64'd1);

    // Reset in T+1 discards the operation
    acc_valid = 1; acc_a = 32'd9; acc_b = 32'd9; step(); idle();
    rst = 1; step(); rst = 0;
    lit("rst_mid", 32'h0, 32'h0);
    chk("rst_mid_busy", {63'b0, busy}, 64'd0);
    step();
    lit("rst_after", 32'h0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst       = ($urandom_range(0, 99) < 2);
      flush     = ($urandom_range(0, 99) < 6);
      we_hi     = ($urandom_range(0, 99) < 15);
      we_lo     = ($urandom_range(0, 99) < 15);
      hi_i      = $urandom;
      lo_i      = $urandom;
      acc_valid = ($urandom_range(0, 99) < 60);
      acc_op    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       acc_a = 32'hFFFFFFFF;
        1:       acc_a = 32'h80000000;
        default: acc_a = $urandom;
      endcase
      acc_b = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
      step();
    end
    idle();
    rst = 0;
    step();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
